// File: rtl/ahb_lite_master_port_if.sv
// AHB-Lite bus signals between the master port and a slave or fabric.
interface ahb_lite_master_port_if;
    logic        HSEL;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master_port.sv
// AHB-Lite single-beat master: turns local read/write requests into pipelined
// NONSEQ transfers, absorbs wait states and two-cycle error responses, and
// returns right-justified read data with an error flag.
// Optional macro AHB_MASTER_TIMEOUT_EN: aborts a data phase stuck with
// HREADY low for TIMEOUT_CYCLES consecutive cycles.
module ahb_lite_master_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_error,
    ahb_lite_master_port_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,     // normal pipelined operation
        ST_ERR,     // second error cycle: waiting for HREADY to close the failing beat
        ST_CANCEL,  // reporting the cancelled address-stage request
        ST_DRAIN    // one quiet cycle after the last error response
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [1:0] size;
        logic [1:0] lane;
    } d_stage_t;

    // Lane shift in bits for a given size and byte offset
    function automatic logic [4:0] f_shamt(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    return {lane, 3'b000};
            2'd1:    return {lane[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

    // Keep only the bytes belonging to the transfer size
    function automatic logic [31:0] f_mask(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'd0:    return {24'd0, d[7:0]};
            2'd1:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    state_t      r_state;
    d_stage_t    r_d;
    logic        r_a_valid;
    logic [31:0] r_a_wdata;
    logic [1:0]  r_htrans;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [1:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic        r_rsp_valid;
    logic        r_rsp_error;
    logic [31:0] r_rsp_rdata;

    logic [1:0]  w_size_eff;
    logic [31:0] w_addr_al;
    logic [31:0] w_wdata_lane;
    logic [31:0] w_rdata;
    logic        w_err_start;
    logic        w_timeout;
    logic        w_accept;

    // Request decode: size 3 behaves as word, address aligned to size
    assign w_size_eff   = (req_size == 2'd3) ? 2'd2 : req_size;
    assign w_addr_al    = (w_size_eff == 2'd0) ? req_addr :
                          (w_size_eff == 2'd1) ? {req_addr[31:1], 1'b0} :
                                                 {req_addr[31:2], 2'b00};
    assign w_wdata_lane = f_mask(req_wdata, w_size_eff) << f_shamt(w_size_eff, req_addr[1:0]);
    assign w_rdata      = f_mask(bus.HRDATA >> f_shamt(r_d.size, r_d.lane), r_d.size);

    // First error cycle seen on the data phase
    assign w_err_start  = (r_state == ST_RUN) && r_d.valid && !bus.HREADY && bus.HRESP;

    // Ready blocks new work while an error or timeout abort is in flight
    assign req_ready    = (r_state == ST_RUN) && (!r_a_valid || bus.HREADY) && !w_err_start && !w_timeout;
    assign w_accept     = req_valid && req_ready;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            w_stall;

    assign w_stall   = (r_state == ST_RUN) && r_d.valid && !bus.HREADY && !bus.HRESP;
    assign w_timeout = w_stall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled data-phase cycles
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_to_cnt <= '0;
        end else if (w_stall && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Pipeline, bus-control and response state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_RUN;
            r_d         <= '0;
            r_a_valid   <= 1'b0;
            r_a_wdata   <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;

            case (r_state)
                ST_RUN: begin
                    if (w_err_start) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= ST_ERR;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_d.valid   <= 1'b0;
                        r_htrans    <= HTRANS_IDLE;
                        r_state     <= r_a_valid ? ST_CANCEL : ST_DRAIN;
                    end else begin
                        if (bus.HREADY) begin
                            if (r_d.valid) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_error <= bus.HRESP;
                                r_rsp_rdata <= (bus.HRESP || r_d.write) ? 32'd0 : w_rdata;
                            end
                            r_d <= '{valid: r_a_valid, write: r_hwrite,
                                     size: r_hsize, lane: r_haddr[1:0]};
                            if (r_a_valid) begin
                                r_hwdata <= r_a_wdata;
                            end
                        end
                        if (w_accept) begin
                            r_a_valid <= 1'b1;
                            r_a_wdata <= w_wdata_lane;
                            r_htrans  <= HTRANS_NONSEQ;
                            r_haddr   <= w_addr_al;
                            r_hwrite  <= req_write;
                            r_hsize   <= w_size_eff;
                        end else if (bus.HREADY) begin
                            r_a_valid <= 1'b0;
                            r_htrans  <= HTRANS_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    if (bus.HREADY) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_d.valid   <= 1'b0;
                        r_state     <= r_a_valid ? ST_CANCEL : ST_DRAIN;
                    end
                end
                ST_CANCEL: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b1;
                    r_a_valid   <= 1'b0;
                    r_state     <= ST_DRAIN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.HTRANS = r_htrans;
    assign bus.HSEL   = r_htrans[1];
    assign bus.HADDR  = r_haddr;
    assign bus.HWRITE = r_hwrite;
    assign bus.HSIZE  = {1'b0, r_hsize};
    assign bus.HWDATA = r_hwdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_error  = r_rsp_error;
    assign rsp_rdata  = r_rsp_rdata;

endmodule
